// File: rtl/performance_counters.sv
`default_nettype none
// ============================================================================
// Module      : performance_counters
// Description : Two free-running 64-bit event counters with per-counter event
//               select, synchronous clear and optional sticky wrap flags
//               (enabled by defining PERF_OVERFLOW_IRQ_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module performance_counters #(
    parameter int NUM_EVENTS      = 8,
    parameter int EVENT_IDX_WIDTH = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_EVENTS-1:0]      perf_events,
    input  logic [EVENT_IDX_WIDTH-1:0] cr_perf_event_select0,
    input  logic [EVENT_IDX_WIDTH-1:0] cr_perf_event_select1,
    input  logic [1:0]                 perf_clear,
    output logic [63:0]                perf_event_count0,
    output logic [63:0]                perf_event_count1,
    output logic [1:0]                 perf_overflow_irq
);

    localparam int c_SEL_SPAN = 1 << EVENT_IDX_WIDTH;

    logic [NUM_EVENTS-1:0]      r_event_q;
    logic [EVENT_IDX_WIDTH-1:0] r_sel_q [2];
    logic [63:0]                r_count0;
    logic [63:0]                r_count1;

    logic [EVENT_IDX_WIDTH-1:0] w_sel_in [2];
    logic [63:0]                w_count [2];
    logic [63:0]                w_count_nxt [2];
    logic [c_SEL_SPAN-1:0]      w_event_span;
    logic [1:0]                 w_sel_chg;
    logic [1:0]                 w_hit;

    assign w_sel_in[0] = cr_perf_event_select0;
    assign w_sel_in[1] = cr_perf_event_select1;
    assign w_count[0]  = r_count0;
    assign w_count[1]  = r_count1;

    // Out-of-range selects land on zero padding, so they never count.
    generate
        if (c_SEL_SPAN > NUM_EVENTS) begin : g_pad
            assign w_event_span = {{(c_SEL_SPAN-NUM_EVENTS){1'b0}}, r_event_q};
        end else begin : g_nopad
            assign w_event_span = r_event_q;
        end
    endgenerate

    generate
        for (genvar n = 0; n < 2; n++) begin : g_ctr
            assign w_sel_chg[n]   = (w_sel_in[n] != r_sel_q[n]);
            assign w_hit[n]       = w_event_span[r_sel_q[n]];
            // Select change outranks clear, clear outranks increment.
            assign w_count_nxt[n] = (w_sel_chg[n] || perf_clear[n]) ? 64'd0 :
                                    w_hit[n] ? (w_count[n] + 64'd1) : w_count[n];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_event_q  <= '0;
            r_sel_q[0] <= '0;
            r_sel_q[1] <= '0;
            r_count0   <= 64'd0;
            r_count1   <= 64'd0;
        end else begin
            r_event_q  <= perf_events;
            r_sel_q[0] <= w_sel_in[0];
            r_sel_q[1] <= w_sel_in[1];
            r_count0   <= w_count_nxt[0];
            r_count1   <= w_count_nxt[1];
        end
    end

    assign perf_event_count0 = r_count0;
    assign perf_event_count1 = r_count1;

`ifdef PERF_OVERFLOW_IRQ_EN
    logic [1:0] r_irq;
    logic [1:0] w_wrap;

    assign w_wrap = {&r_count1, &r_count0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 2'b00;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_sel_chg[n] || perf_clear[n]) begin
                    r_irq[n] <= 1'b0;
                end else if (w_hit[n] && w_wrap[n]) begin
                    r_irq[n] <= 1'b1;
                end
            end
        end
    end

    assign perf_overflow_irq = r_irq;
`else
    assign perf_overflow_irq = 2'b00;
`endif

endmodule
`default_nettype wire
